// File: rtl/posit_encoder_8.sv
// posit_encoder_8: pipelined posit packer.
//
// Takes an unpacked posit value (sign, signed scale, fraction, NaR/zero flags)
// and produces the packed N-bit posit word. Truncating rounding throughout.
// Three register stages: saturate/split, build magnitude, apply sign/specials.
//
// Ports:
//   aclk     rising-edge clock
//   reset    asynchronous active-high reset; clears every pipeline register
//   start    input sample valid (one per cycle, no back-pressure)
//   sign     1 = negative value
//   scale    signed scale s, value = (1.frac) * 2^s
//   frac     fraction bits, hidden one excluded, MSB weighs 1/2
//   in_inf   input is NaR
//   in_zero  input is zero
//   result   packed posit word
//   inf      result is NaR
//   zero     result is zero
//   done     result/inf/zero valid this cycle (start delayed by 3 stages)
module posit_encoder_8 #(
  parameter int N  = 8,
  parameter int es = 4,
  parameter int Bs = $clog2(N),
  parameter int SW = es + Bs + 2,
  parameter int FW = N
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sign,
  input  logic signed [SW-1:0] scale,
  input  logic [FW-1:0]        frac,
  input  logic                 in_inf,
  input  logic                 in_zero,
  output logic [N-1:0]         result,
  output logic                 inf,
  output logic                 zero,
  output logic                 done
);

  localparam int KW  = SW - es;
  localparam int PAD = 2*N - 2 - es - FW;
  localparam logic signed [SW-1:0] MAX_S = SW'((N-2) * (1 << es));
  localparam logic signed [SW-1:0] MIN_S = -MAX_S;

  // Clamp scale to +/-maxscale; a clamped value loses its fraction so it
  // lands exactly on maxpos/minpos.
  function automatic logic [SW+FW-1:0] saturate(input logic signed [SW-1:0] s,
                                                input logic [FW-1:0]        f);
    if (s > MAX_S)
      return {MAX_S, {FW{1'b0}}};
    else if (s < MIN_S)
      return {MIN_S, {FW{1'b0}}};
    else
      return {s, f};
  endfunction

  // Build the N-bit magnitude word (sign bit 0) from regime k, exponent e and
  // fraction f. A 2N-bit word holds "10"/"01" + e + f left-aligned; shifting it
  // right grows the regime run: arithmetic shift replicates ones for k>=0,
  // logical shift inserts zeros for k<0 (~k == -k-1 extra zeros). The top N-1
  // bits become the magnitude; everything below is truncated.
  function automatic logic [N-1:0] pack_mag(input logic signed [KW-1:0] k,
                                            input logic [es-1:0]        e,
                                            input logic [FW-1:0]        f);
    logic signed [2*N-1:0] sbase;
    logic [2*N-1:0]        ubase;
    logic [2*N-1:0]        word;
    sbase = {2'b10, e, f, {PAD{1'b0}}};
    ubase = {2'b01, e, f, {PAD{1'b0}}};
    if (k[KW-1] == 1'b0)
      word = sbase >>> Bs'(k);
    else
      word = ubase >> Bs'(~k);
    return N'(word >> (N+1));
  endfunction

  logic [SW+FW-1:0]        sat_w;
  logic signed [SW-1:0]    sat_scale;
  logic [FW-1:0]           sat_frac;

  logic                    vld_p0, sign_p0, inf_p0, zero_p0;
  logic signed [KW-1:0]    k_p0;
  logic [es-1:0]           e_p0;
  logic [FW-1:0]           frac_p0;

  logic                    vld_p1, sign_p1, inf_p1, zero_p1;
  logic [N-1:0]            mag_p1;

  logic                    vld_p2, inf_p2, zero_p2;
  logic [N-1:0]            res_p2;

  always_comb begin
    sat_w     = saturate(scale, frac);
    sat_scale = sat_w[SW+FW-1:FW];
    sat_frac  = sat_w[FW-1:0];
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      sign_p0 <= 1'b0;
      inf_p0  <= 1'b0;
      zero_p0 <= 1'b0;
      k_p0    <= '0;
      e_p0    <= '0;
      frac_p0 <= '0;
      vld_p1  <= 1'b0;
      sign_p1 <= 1'b0;
      inf_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      mag_p1  <= '0;
      vld_p2  <= 1'b0;
      inf_p2  <= 1'b0;
      zero_p2 <= 1'b0;
      res_p2  <= '0;
    end else begin
      // Stage p0: saturate scale, split into regime k and exponent e
      vld_p0  <= start;
      sign_p0 <= sign;
      inf_p0  <= in_inf;
      zero_p0 <= in_zero;
      k_p0    <= KW'(sat_scale >>> es);
      e_p0    <= sat_scale[es-1:0];
      frac_p0 <= sat_frac;

      // Stage p1: regime + exponent + fraction packed into the magnitude
      vld_p1  <= vld_p0;
      sign_p1 <= sign_p0;
      inf_p1  <= inf_p0;
      zero_p1 <= zero_p0;
      mag_p1  <= pack_mag(k_p0, e_p0, frac_p0);

      // Stage p2: two's complement for negatives, NaR over zero over normal
      vld_p2 <= vld_p1;
      if (inf_p1) begin
        res_p2  <= {1'b1, {(N-1){1'b0}}};
        inf_p2  <= 1'b1;
        zero_p2 <= 1'b0;
      end else if (zero_p1) begin
        res_p2  <= '0;
        inf_p2  <= 1'b0;
        zero_p2 <= 1'b1;
      end else begin
        res_p2  <= sign_p1 ? (~mag_p1 + 1'b1) : mag_p1;
        inf_p2  <= 1'b0;
        zero_p2 <= 1'b0;
      end
    end
  end

  assign result = res_p2;
  assign inf    = inf_p2;
  assign zero   = zero_p2;
  assign done   = vld_p2;

endmodule

// File: tb/tb_posit_encoder_8.sv
module tb_posit_encoder_8;

  logic              aclk;
  logic              reset;
  logic              start;
  logic              sign;
  logic signed [8:0] scale;
  logic [7:0]        frac;
  logic              in_inf;
  logic              in_zero;
  logic [7:0]        result;
  logic              inf;
  logic              zero;
  logic              done;

  int checks;
  int errors;

  posit_encoder_8 dut (
    .aclk    (aclk),
    .reset   (reset),
    .start   (start),
    .sign    (sign),
    .scale   (scale),
    .frac    (frac),
    .in_inf  (in_inf),
    .in_zero (in_zero),
    .result  (result),
    .inf     (inf),
    .zero    (zero),
    .done    (done)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start   = 1'b0;
    sign    = 1'b0;
    scale   = 9'sd0;
    frac    = 8'h00;
    in_inf  = 1'b0;
    in_zero = 1'b0;
  endtask

  // One isolated sample: driven just after an edge, result checked just after
  // the third following edge, and done must drop one cycle later.
  task automatic run_one(input string tag, input logic sg, input int sc,
                         input logic [7:0] fr, input logic ni, input logic nz,
                         input logic [7:0] er, input logic ei, input logic ez);
    @(posedge aclk); #1;
    start = 1'b1; sign = sg; scale = 9'(sc); frac = fr; in_inf = ni; in_zero = nz;
    @(posedge aclk); #1;
    idle_inputs();
    @(posedge aclk);
    @(posedge aclk); #1;
    check({tag, "_done"}, {7'd0, done}, 8'd1);
    check({tag, "_res"},  result, er);
    check({tag, "_inf"},  {7'd0, inf},  {7'd0, ei});
    check({tag, "_zero"}, {7'd0, zero}, {7'd0, ez});
    @(posedge aclk); #1;
    check({tag, "_done_end"}, {7'd0, done}, 8'd0);
  endtask

  int          st  [0:9] = '{1, 1, 1, 1, 0, 1, 0, 0, 0, 0};
  int          sc  [0:9] = '{0, 1, 16, -1, 0, 80, 0, 0, 0, 0};
  logic [7:0]  exr [0:9] = '{8'h40, 8'h42, 8'h60, 8'h3E, 8'h00, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();

    // Reset state
    @(posedge aclk);
    @(posedge aclk); #1;
    check("rst_result", result, 8'h00);
    check("rst_inf",    {7'd0, inf},  8'd0);
    check("rst_zero",   {7'd0, zero}, 8'd0);
    check("rst_done",   {7'd0, done}, 8'd0);
    reset = 1'b0;
    @(posedge aclk); #1;
    check("post_rst_done", {7'd0, done}, 8'd0);

    // Basic encodes, regime, sign, truncation
    run_one("s0",      1'b0,    0, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0);
    run_one("s1",      1'b0,    1, 8'h00, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0);
    run_one("f80",     1'b0,    0, 8'h80, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);
    run_one("s16",     1'b0,   16, 8'h00, 1'b0, 1'b0, 8'h60, 1'b0, 1'b0);
    run_one("sm1",     1'b0,   -1, 8'h00, 1'b0, 1'b0, 8'h3E, 1'b0, 1'b0);
    run_one("neg0",    1'b1,    0, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b0);
    run_one("s80",     1'b0,   80, 8'h00, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0);
    run_one("s95ff",   1'b0,   95, 8'hFF, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0);
    run_one("negm1",   1'b1,   -1, 8'h00, 1'b0, 1'b0, 8'hC2, 1'b0, 1'b0);

    // Saturation
    run_one("sat_hi",  1'b0,  200, 8'h5A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_one("sat_lo",  1'b0, -200, 8'hA5, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    run_one("s96",     1'b0,   96, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_one("sm96",    1'b0,  -96, 8'hFF, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    run_one("sm97",    1'b0,  -97, 8'hFF, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    run_one("nsat_hi", 1'b1,  200, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
    run_one("nsat_lo", 1'b1, -200, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

    // Specials
    run_one("nar",     1'b0,   16, 8'h12, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0);
    run_one("zro",     1'b1,   16, 8'h12, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    run_one("both",    1'b0,    0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0);

    // Throughput: back-to-back samples plus a one-cycle gap
    for (int c = 0; c < 10; c++) begin
      @(posedge aclk); #1;
      if (c >= 3) begin
        check($sformatf("tp_done%0d", c - 3), {7'd0, done}, 8'(st[c-3]));
        if (st[c-3] != 0)
          check($sformatf("tp_res%0d", c - 3), result, exr[c-3]);
      end
      if (c < 7) begin
        start = (st[c] != 0);
        scale = 9'(sc[c]);
      end else begin
        idle_inputs();
      end
    end

    // Reset with two samples in flight
    @(posedge aclk); #1;
    start = 1'b1; scale = 9'sd16;
    @(posedge aclk); #1;
    start = 1'b1; scale = 9'sd1;
    @(posedge aclk); #1;
    idle_inputs();
    reset = 1'b1;
    #1;
    check("mid_rst_result", result, 8'h00);
    check("mid_rst_inf",    {7'd0, inf},  8'd0);
    check("mid_rst_zero",   {7'd0, zero}, 8'd0);
    check("mid_rst_done",   {7'd0, done}, 8'd0);
    @(posedge aclk); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      check($sformatf("rel_done%0d", c), {7'd0, done}, 8'd0);
    end

    // Fresh sample after reset release
    run_one("after_rst", 1'b0, 16, 8'h00, 1'b0, 1'b0, 8'h60, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
